// File: rtl/toy_bus_darbn_node.sv
// Round-robin N_CH:1 request arbiter, zero-latency request path, in-order ack return through an outstanding-channel FIFO.
// Backpressure: a stalled grant is locked until accepted; pushes stop when the tracker is full. Option: TOY_BUS_DARBN_UNEXP_ACK_EN.
module toy_bus_darbn_node #(
    parameter int N_CH      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int ID_W      = 4,
    parameter int SB_W      = 10,
    parameter int OST_DEPTH = 8,
    parameter int OP_W      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_CH-1:0]                 in_req_vld,
    output logic [N_CH-1:0]                 in_req_rdy,
    input  logic [N_CH*ADDR_W-1:0]          in_req_addr,
    input  logic [N_CH*(DATA_W/8)-1:0]      in_req_strb,
    input  logic [N_CH*DATA_W-1:0]          in_req_data,
    input  logic [N_CH*OP_W-1:0]            in_req_opcode,
    input  logic [N_CH*ID_W-1:0]            in_req_src_id,
    input  logic [N_CH*ID_W-1:0]            in_req_tgt_id,
    input  logic [N_CH*SB_W-1:0]            in_req_sideband,
    output logic                            out_req_vld,
    input  logic                            out_req_rdy,
    output logic [ADDR_W-1:0]               out_req_addr,
    output logic [DATA_W/8-1:0]             out_req_strb,
    output logic [DATA_W-1:0]               out_req_data,
    output logic [OP_W-1:0]                 out_req_opcode,
    output logic [ID_W-1:0]                 out_req_src_id,
    output logic [ID_W-1:0]                 out_req_tgt_id,
    output logic [SB_W-1:0]                 out_req_sideband,
    input  logic                            out_ack_vld,
    output logic                            out_ack_rdy,
    input  logic [OP_W-1:0]                 out_ack_opcode,
    input  logic [DATA_W-1:0]               out_ack_data,
    input  logic [SB_W-1:0]                 out_ack_sideband,
    input  logic [ID_W-1:0]                 out_ack_src_id,
    input  logic [ID_W-1:0]                 out_ack_tgt_id,
    output logic [N_CH-1:0]                 in_ack_vld,
    input  logic [N_CH-1:0]                 in_ack_rdy,
    output logic [N_CH*OP_W-1:0]            in_ack_opcode,
    output logic [N_CH*DATA_W-1:0]          in_ack_data,
    output logic [N_CH*SB_W-1:0]            in_ack_sideband,
    output logic [N_CH*ID_W-1:0]            in_ack_src_id,
    output logic [N_CH*ID_W-1:0]            in_ack_tgt_id,
    output logic [$clog2(OST_DEPTH+1)-1:0]  ost_cnt
`ifdef TOY_BUS_DARBN_UNEXP_ACK_EN
    ,
    output logic                            err_unexp_ack
`endif
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int PTR_W = $clog2(OST_DEPTH);
    localparam int CNT_W = $clog2(OST_DEPTH+1);
`ifdef TOY_BUS_DARBN_UNEXP_ACK_EN
    localparam bit UNEXP_ACCEPT = 1'b1;
`else
    localparam bit UNEXP_ACCEPT = 1'b0;
`endif

    logic [CH_W-1:0]  r_rr_ptr;
    logic [CH_W-1:0]  r_lock_ch;
    logic             r_lock;
    logic [CH_W-1:0]  r_ost_mem [OST_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic [CH_W-1:0]  w_grant;
    logic [CH_W-1:0]  w_head;
    logic [CH_W:0]    w_sum;
    logic [CH_W-1:0]  w_idx;
    logic             w_any;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_cnt == CNT_W'(OST_DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_head  = r_ost_mem[r_rd_ptr];

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        w_grant = r_rr_ptr;
        w_any   = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        if (r_lock) begin
            w_grant = r_lock_ch;
            w_any   = in_req_vld[r_lock_ch];
        end else begin
            for (int i = N_CH-1; i >= 0; i--) begin
                w_sum = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
                w_idx = (w_sum >= (CH_W+1)'(N_CH)) ? CH_W'(w_sum - (CH_W+1)'(N_CH)) : CH_W'(w_sum);
                if (in_req_vld[w_idx]) begin
                    w_grant = w_idx;
                    w_any   = 1'b1;
                end
            end
        end
    end

    assign out_req_vld = w_any & ~w_full;
    assign w_push      = out_req_vld & out_req_rdy;

    always_comb begin
        in_req_rdy       = '0;
        out_req_addr     = '0;
        out_req_strb     = '0;
        out_req_data     = '0;
        out_req_opcode   = '0;
        out_req_src_id   = '0;
        out_req_tgt_id   = '0;
        out_req_sideband = '0;
        if (out_req_vld) in_req_rdy[w_grant] = out_req_rdy;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant == CH_W'(i)) begin
                out_req_addr     = in_req_addr[i*ADDR_W +: ADDR_W];
                out_req_strb     = in_req_strb[i*(DATA_W/8) +: DATA_W/8];
                out_req_data     = in_req_data[i*DATA_W +: DATA_W];
                out_req_opcode   = in_req_opcode[i*OP_W +: OP_W];
                out_req_src_id   = in_req_src_id[i*ID_W +: ID_W];
                out_req_tgt_id   = in_req_tgt_id[i*ID_W +: ID_W];
                out_req_sideband = in_req_sideband[i*SB_W +: SB_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
        end else begin
            r_lock    <= out_req_vld & ~out_req_rdy;
            r_lock_ch <= w_grant;
            if (w_push) r_rr_ptr <= (w_grant == CH_W'(N_CH-1)) ? '0 : w_grant + 1'b1;
        end
    end

    always_comb begin
        in_ack_vld  = '0;
        out_ack_rdy = UNEXP_ACCEPT;
        if (!w_empty) begin
            in_ack_vld[w_head] = out_ack_vld;
            out_ack_rdy        = in_ack_rdy[w_head];
        end
    end

    assign w_pop = out_ack_vld & out_ack_rdy & ~w_empty;

    assign in_ack_opcode   = {N_CH{out_ack_opcode}};
    assign in_ack_data     = {N_CH{out_ack_data}};
    assign in_ack_sideband = {N_CH{out_ack_sideband}};
    assign in_ack_src_id   = {N_CH{out_ack_src_id}};
    assign in_ack_tgt_id   = {N_CH{out_ack_tgt_id}};

    always_ff @(posedge clk) begin
        if (w_push) r_ost_mem[r_wr_ptr] <= w_grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    assign ost_cnt = r_cnt;

`ifdef TOY_BUS_DARBN_UNEXP_ACK_EN
    logic r_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else if (out_ack_vld && w_empty) r_err <= 1'b1;
    end
    assign err_unexp_ack = r_err;
`endif

endmodule

// File: tb/tb_toy_bus_darbn_node.sv
// Bench for toy_bus_darbn_node: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a queue-based transaction model.
module tb_toy_bus_darbn_node;
    localparam int N_CH = 4, ADDR_W = 32, DATA_W = 64, ID_W = 4, SB_W = 10, OST_DEPTH = 8, OP_W = 4;
    localparam int STRB_W = DATA_W/8;
`ifdef TOY_BUS_DARBN_UNEXP_ACK_EN
    localparam bit UNEXP = 1'b1;
`else
    localparam bit UNEXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N_CH-1:0]         in_req_vld, in_req_rdy;
    logic [N_CH*ADDR_W-1:0]  in_req_addr;
    logic [N_CH*STRB_W-1:0]  in_req_strb;
    logic [N_CH*DATA_W-1:0]  in_req_data;
    logic [N_CH*OP_W-1:0]    in_req_opcode;
    logic [N_CH*ID_W-1:0]    in_req_src_id, in_req_tgt_id;
    logic [N_CH*SB_W-1:0]    in_req_sideband;
    logic                    out_req_vld, out_req_rdy;
    logic [ADDR_W-1:0]       out_req_addr;
    logic [STRB_W-1:0]       out_req_strb;
    logic [DATA_W-1:0]       out_req_data;
    logic [OP_W-1:0]         out_req_opcode;
    logic [ID_W-1:0]         out_req_src_id, out_req_tgt_id;
    logic [SB_W-1:0]         out_req_sideband;
    logic                    out_ack_vld, out_ack_rdy;
    logic [OP_W-1:0]         out_ack_opcode;
    logic [DATA_W-1:0]       out_ack_data;
    logic [SB_W-1:0]         out_ack_sideband;
    logic [ID_W-1:0]         out_ack_src_id, out_ack_tgt_id;
    logic [N_CH-1:0]         in_ack_vld, in_ack_rdy;
    logic [N_CH*OP_W-1:0]    in_ack_opcode;
    logic [N_CH*DATA_W-1:0]  in_ack_data;
    logic [N_CH*SB_W-1:0]    in_ack_sideband;
    logic [N_CH*ID_W-1:0]    in_ack_src_id, in_ack_tgt_id;
    logic [$clog2(OST_DEPTH+1)-1:0] ost_cnt;
`ifdef TOY_BUS_DARBN_UNEXP_ACK_EN
    logic err_unexp_ack;
`endif

    toy_bus_darbn_node #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                         .SB_W(SB_W), .OST_DEPTH(OST_DEPTH), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .in_req_vld(in_req_vld), .in_req_rdy(in_req_rdy), .in_req_addr(in_req_addr),
        .in_req_strb(in_req_strb), .in_req_data(in_req_data), .in_req_opcode(in_req_opcode),
        .in_req_src_id(in_req_src_id), .in_req_tgt_id(in_req_tgt_id), .in_req_sideband(in_req_sideband),
        .out_req_vld(out_req_vld), .out_req_rdy(out_req_rdy), .out_req_addr(out_req_addr),
        .out_req_strb(out_req_strb), .out_req_data(out_req_data), .out_req_opcode(out_req_opcode),
        .out_req_src_id(out_req_src_id), .out_req_tgt_id(out_req_tgt_id), .out_req_sideband(out_req_sideband),
        .out_ack_vld(out_ack_vld), .out_ack_rdy(out_ack_rdy), .out_ack_opcode(out_ack_opcode),
        .out_ack_data(out_ack_data), .out_ack_sideband(out_ack_sideband),
        .out_ack_src_id(out_ack_src_id), .out_ack_tgt_id(out_ack_tgt_id),
        .in_ack_vld(in_ack_vld), .in_ack_rdy(in_ack_rdy), .in_ack_opcode(in_ack_opcode),
        .in_ack_data(in_ack_data), .in_ack_sideband(in_ack_sideband),
        .in_ack_src_id(in_ack_src_id), .in_ack_tgt_id(in_ack_tgt_id),
        .ost_cnt(ost_cnt)
`ifdef TOY_BUS_DARBN_UNEXP_ACK_EN
        , .err_unexp_ack(err_unexp_ack)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: a held grant, a round-robin start channel, and a queue of outstanding channels.
    int m_rr = 0;
    int m_held = -1;
    int m_q[$];
    bit m_err = 1'b0;

    int              e_g;
    bit              e_vld;
    bit              e_ack_rdy;
    logic [N_CH-1:0] e_req_rdy;
    logic [N_CH-1:0] e_ack_vld;

    function automatic void model_eval();
        bit full;
        bit found;
        full = (m_q.size() == OST_DEPTH);
        e_g = -1; e_vld = 1'b0; e_req_rdy = '0; e_ack_vld = '0; e_ack_rdy = UNEXP;
        if (m_held >= 0) e_g = m_held;
        else begin
            found = 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                if (!found && in_req_vld[(m_rr + k) % N_CH]) begin
                    e_g = (m_rr + k) % N_CH;
                    found = 1'b1;
                end
            end
        end
        if (e_g >= 0) e_vld = in_req_vld[e_g] && !full;
        if (e_vld) e_req_rdy[e_g] = out_req_rdy;
        if (m_q.size() > 0) begin
            e_ack_vld[m_q[0]] = out_ack_vld;
            e_ack_rdy = in_ack_rdy[m_q[0]];
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        bit push, pop;
        if (rst) begin
            m_rr = 0; m_held = -1; m_q.delete(); m_err = 1'b0;
        end else begin
            model_eval();
            push = e_vld && out_req_rdy;
            pop  = (m_q.size() > 0) && out_ack_vld && e_ack_rdy;
            if (UNEXP && m_q.size() == 0 && out_ack_vld) m_err = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back(e_g);
                m_rr = (e_g + 1) % N_CH;
                m_held = -1;
            end else if (e_vld) m_held = e_g;
            else m_held = -1;
        end
    end

    always @(negedge clk) begin
        model_eval();
        chk("out_req_vld", out_req_vld, e_vld);
        chk("in_req_rdy", in_req_rdy, e_req_rdy);
        if (e_vld) begin
            chk("out_req_addr", out_req_addr, in_req_addr[e_g*ADDR_W +: ADDR_W]);
            chk("out_req_strb", out_req_strb, in_req_strb[e_g*STRB_W +: STRB_W]);
            chk("out_req_data", out_req_data, in_req_data[e_g*DATA_W +: DATA_W]);
            chk("out_req_opcode", out_req_opcode, in_req_opcode[e_g*OP_W +: OP_W]);
            chk("out_req_src_id", out_req_src_id, in_req_src_id[e_g*ID_W +: ID_W]);
            chk("out_req_tgt_id", out_req_tgt_id, in_req_tgt_id[e_g*ID_W +: ID_W]);
            chk("out_req_sideband", out_req_sideband, in_req_sideband[e_g*SB_W +: SB_W]);
        end
        chk("in_ack_vld", in_ack_vld, e_ack_vld);
        chk("out_ack_rdy", out_ack_rdy, e_ack_rdy);
        chk("ost_cnt", ost_cnt, m_q.size());
        for (int c = 0; c < N_CH; c++) begin
            chk("ack_bcast_data", in_ack_data[c*DATA_W +: DATA_W], out_ack_data);
            chk("ack_bcast_op", in_ack_opcode[c*OP_W +: OP_W], out_ack_opcode);
            chk("ack_bcast_sb", in_ack_sideband[c*SB_W +: SB_W], out_ack_sideband);
            chk("ack_bcast_src", in_ack_src_id[c*ID_W +: ID_W], out_ack_src_id);
            chk("ack_bcast_tgt", in_ack_tgt_id[c*ID_W +: ID_W], out_ack_tgt_id);
        end
`ifdef TOY_BUS_DARBN_UNEXP_ACK_EN
        chk("err_unexp_ack", err_unexp_ack, m_err);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req(input int c, input bit fixed_src);
        in_req_addr[c*ADDR_W +: ADDR_W]   = $urandom;
        in_req_strb[c*STRB_W +: STRB_W]   = STRB_W'($urandom);
        in_req_data[c*DATA_W +: DATA_W]   = {$urandom, $urandom};
        in_req_opcode[c*OP_W +: OP_W]     = OP_W'($urandom);
        in_req_src_id[c*ID_W +: ID_W]     = fixed_src ? ID_W'(c) : ID_W'($urandom);
        in_req_tgt_id[c*ID_W +: ID_W]     = ID_W'($urandom);
        in_req_sideband[c*SB_W +: SB_W]   = SB_W'($urandom);
    endtask

    task automatic rand_ack();
        out_ack_opcode   = OP_W'($urandom);
        out_ack_data     = {$urandom, $urandom};
        out_ack_sideband = SB_W'($urandom);
        out_ack_src_id   = ID_W'($urandom);
        out_ack_tgt_id   = ID_W'($urandom);
    endtask

    initial begin
        logic [N_CH-1:0] seq [3];
        logic [N_CH-1:0] req_hs;
        bit              ack_hs;
        seq = '{4'b1000, 4'b0010, 4'b0010};
        in_req_vld = '0; out_req_rdy = 1'b0; out_ack_vld = 1'b0; in_ack_rdy = '0;
        for (int c = 0; c < N_CH; c++) rand_req(c, 1'b1);
        rand_ack();
        #1 rst = 1'b1;
        in_req_vld = 4'b0100;
        @(negedge clk);
        chk("rst_out_req_vld", out_req_vld, 1);
        chk("rst_ost_cnt", ost_cnt, 0);
        chk("rst_out_ack_rdy", out_ack_rdy, UNEXP);
        tick(); rst = 1'b0; in_req_vld = '1; out_req_rdy = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_grant", out_req_src_id, i % N_CH);
            chk("rr_vld", out_req_vld, 1);
            tick();
        end
        @(negedge clk);
        chk("full_vld", out_req_vld, 0);
        chk("full_cnt", ost_cnt, 8);

        tick(); out_ack_vld = 1'b1; in_ack_rdy = '1;
        @(negedge clk);
        chk("fullpop_req_blocked", out_req_vld, 0);
        chk("fullpop_ack_rdy", out_ack_rdy, 1);
        chk("fullpop_ack_vld", in_ack_vld, 4'b0001);
        tick(); out_ack_vld = 1'b0;
        @(negedge clk);
        chk("fullpop_cnt7", ost_cnt, 7);
        chk("fullpop_req_next", out_req_vld, 1);
        tick(); in_req_vld = '0;
        @(negedge clk);
        chk("fullpop_cnt8", ost_cnt, 8);

        tick(); out_ack_vld = 1'b1;
        tick(); tick(); tick(); out_ack_vld = 1'b0;
        @(negedge clk);
        chk("pre_rst_cnt5", ost_cnt, 5);
        tick(); rst = 1'b1; out_ack_vld = 1'b1;
        @(negedge clk);
        chk("rst_clears_cnt", ost_cnt, 0);
        chk("rst_unexp_rdy", out_ack_rdy, UNEXP);
        chk("rst_unexp_vld", in_ack_vld, 0);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("unexp_rdy", out_ack_rdy, UNEXP);
        chk("unexp_dropped", in_ack_vld, 0);
        tick(); out_ack_vld = 1'b0;
`ifdef TOY_BUS_DARBN_UNEXP_ACK_EN
        @(negedge clk);
        chk("unexp_err_set", err_unexp_ack, 1);
`endif

        tick(); in_req_vld = 4'b0010; out_req_rdy = 1'b1;
        tick(); in_req_vld = '0; out_ack_vld = 1'b1; in_ack_rdy = 4'b1101; rand_ack();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ackstall_rdy", out_ack_rdy, 0);
            chk("ackstall_vld", in_ack_vld, 4'b0010);
            chk("ackstall_cnt", ost_cnt, 1);
            tick();
        end
        in_ack_rdy = '1;
        @(negedge clk);
        chk("ackstall_release", out_ack_rdy, 1);
        tick(); out_ack_vld = 1'b0;
        @(negedge clk);
        chk("ackstall_cnt0", ost_cnt, 0);

        tick(); rst = 1'b1;
        tick(); rst = 1'b0; in_req_vld = 4'b0100; out_req_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lock_stall_src", out_req_src_id, 2);
            tick();
        end
        in_req_vld = 4'b0101;
        @(negedge clk);
        chk("lock_hold_src", out_req_src_id, 2);
        tick(); out_req_rdy = 1'b1;
        @(negedge clk);
        chk("lock_hs_src", out_req_src_id, 2);
        chk("lock_hs_rdy", in_req_rdy, 4'b0100);
        tick(); in_req_vld = 4'b0001;
        @(negedge clk);
        chk("lock_next_src", out_req_src_id, 0);
        tick(); in_req_vld = '0;

        tick(); rst = 1'b1;
        tick(); rst = 1'b0; in_req_vld = 4'b1000;
        tick(); in_req_vld = 4'b0010;
        tick(); tick(); in_req_vld = '0;
        @(negedge clk);
        chk("order_cnt3", ost_cnt, 3);
        tick(); out_ack_vld = 1'b1; in_ack_rdy = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("order_ack_vld", in_ack_vld, seq[i]);
            chk("order_cnt", ost_cnt, 3 - i);
            tick(); rand_ack();
        end
        out_ack_vld = 1'b0;
        @(negedge clk);
        chk("order_cnt0", ost_cnt, 0);

        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            req_hs = in_req_vld & in_req_rdy;
            ack_hs = out_ack_vld & out_ack_rdy;
            tick();
            rst = ($urandom_range(0, 599) == 0);
            for (int c = 0; c < N_CH; c++) begin
                if (req_hs[c] || !in_req_vld[c]) begin
                    in_req_vld[c] = ($urandom_range(0, 2) != 0);
                    rand_req(c, 1'b0);
                end
            end
            if (ack_hs || !out_ack_vld) begin
                out_ack_vld = $urandom_range(0, 1) == 1;
                rand_ack();
            end
            out_req_rdy = ($urandom_range(0, 3) != 0);
            in_ack_rdy  = N_CH'($urandom);
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
